cp0_ctrl: RTL and testbench
===========================

// Module: cp0_ctrl
// PURPOSE
// Parametrised CP0 system-control unit for the MIPS32 core: the CP0 register file plus exception commit, ERET,
// interrupt pending/masking and a prescaled Count/Compare timer. It sits beside the MEM/WB boundary.
// It accepts one committed exception or ERET per cycle from the exception arbiter, and serves MFC0/MTC0.
// It drives the interrupt request and the redirect PC back to the pipeline.
// PARAMETERS
// HW_INT_NUM  6             number of external interrupt lines, 1..6; mapped to Cause.IP[2+:HW_INT_NUM]
// COUNT_DIV   2             Count increments once every COUNT_DIV clocks, 1..16
// EXC_VECTOR  32'hBFC00380  redirect target for every exception, including interrupts
// PRID_VAL    32'h004C0102  read-only PRId value
// PORTS
// clk          in   1           clock; all state updates on posedge
// rst          in   1           synchronous reset, active-high
// we_i         in   1           MTC0 write enable
// waddr_i      in   5           MTC0 register number
// wdata_i      in   32          MTC0 data
// raddr_i      in   5           MFC0 register number
// rdata_o      out  32          MFC0 data; combinational from current register state
// int_i        in   HW_INT_NUM  external interrupt levels, sampled every cycle
// exc_valid_i  in   1           commit exception this cycle
// exc_code_i   in   5           ExcCode: 0 Int, 4 AdEL, 5 AdES, 8 Sys, 9 Bp, 10 RI, 12 Ov, 13 Tr
// exc_pc_i     in   32          PC of the faulting instruction
// exc_ds_i     in   1           faulting instruction is in a delay slot
// exc_bad_i    in   32          bad address; meaningful for AdEL/AdES only
// eret_i       in   1           commit ERET this cycle
// int_req_o    out  1           interrupt request to the pipeline; registered
// flush_o      out  1           exception or ERET committed; 1-cycle pulse
// redirect_o   out  32          EXC_VECTOR on exception, EPC on ERET; valid while flush_o=1
// status_o, cause_o, epc_o  out  32  live register copies for forwarding
// BEHAVIOUR
// Reset values
//  - Count=0, Compare=0, BadVAddr=0, EPC=0, Cause=0
//  - Status=32'h0040_0000 (BEV=1, EXL=0, IE=0, IM=0)
//  - prescaler=0; int_req_o, flush_o and timer_int are all 0; redirect_o=0
// Timer
//  - prescaler counts 0..COUNT_DIV-1; when it wraps, Count+1 (mod 2^32)
//  - when Count becomes equal to Compare on a tick, timer_int (Cause.TI, bit30) sets; it is sticky
//  - an MTC0 write to Compare clears TI; Compare=0 is not special
// Interrupt pending
//  - Cause.IP[7:2] = int_i, zero-extended to 6 bits; IP7 |= TI
//  - Cause.IP[1:0] are software bits, written by MTC0 only
//  - int_req_o (registered) = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM)
// Writable fields
//  - Count, Compare, EPC: full 32 bits
//  - Status: IM[15:8], EXL[1], IE[0]; BEV is read-only 1
//  - Cause: IP[9:8] only
//  - PRId, Config (32'h0000_8000), BadVAddr: read-only; writes are ignored
//  - unmapped addresses read 0
// Exception commit (exc_valid_i=1)
//  - Cause.ExcCode <= exc_code_i
//  - if Status.EXL=0: EPC <= exc_ds_i ? exc_pc_i-4 : exc_pc_i; Cause.BD <= exc_ds_i
//  - if Status.EXL=1: EPC and BD are unchanged (nested exception)
//  - Status.EXL <= 1
//  - BadVAddr <= exc_bad_i for codes 4/5 only
//  - flush_o=1, redirect_o=EXC_VECTOR on the next cycle
// ERET commit
//  - Status.EXL <= 0; flush_o=1, redirect_o=EPC value (including any same-cycle MTC0 EPC)
// Same-cycle priority
//  - rst > exc_valid_i > eret_i > MTC0 for every field both sources touch
//  - the MTC0 write to fields not touched by the winner still applies
//  - an MTC0 write to Count beats that cycle's increment; prescaler keeps running
// Read timing
//  - rdata_o reflects pre-write state, so a same-cycle MTC0 is not visible; pipeline forwards
// Reset mid-operation
//  - all state, including the prescaler phase, returns to reset values on the next edge
//  - no pending flush survives reset
// STRUCTURE
//  - shared package/defines.vh: CP0 register numbers (Count 9, Compare 11, Status 12, Cause 13, EPC 14,
//    PRId 15, Config 16, BadVAddr 8), ExcCode constants, Status/Cause bit-position constants
//  - sub-module cp0_timer: prescaler, Count, Compare, TI
//  - cp0_ctrl holds the remaining registers, commit logic and read mux
// TESTING
// 1. reset; COUNT_DIV=2; MTC0 Compare=5 -> Count=5 after 10 cycles; TI=1, Cause bit30=1;
//    MTC0 Compare -> TI=0
// 2. Status=32'h0000_0401; int_i[0]=1 -> int_req_o=1 one cycle later; set EXL=1 -> int_req_o=0
// 3. exc code 4, pc=32'h8000_0104, ds=1, bad=32'h1235 -> EPC=32'h8000_0100, BD=1, ExcCode=4,
//    BadVAddr=32'h1235, flush_o pulse, redirect_o=32'hBFC00380
// 4. nested: with EXL=1, exc code 8, pc=32'h8000_0200 -> EPC unchanged, ExcCode=8; ERET -> EXL=0,
//    redirect_o=old EPC
// 5. same cycle: exception plus MTC0 EPC=32'hDEAD_0000 -> EPC=exc value; MTC0 Status IM kept
// 6. rst asserted mid-count with TI=1 -> all outputs at reset values next cycle;
//    HW_INT_NUM=2 -> IP[7:4]=0 except TI

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and Status/Cause field positions.
package cp0_pkg;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;
    localparam logic [4:0] REG_CONFIG   = 5'd16;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;
    localparam logic [4:0] EXC_TR   = 5'd13;

    localparam int unsigned ST_IE      = 0;
    localparam int unsigned ST_EXL     = 1;
    localparam int unsigned ST_IM_LSB  = 8;
    localparam int unsigned ST_BEV     = 22;
    localparam int unsigned CA_EXC_LSB = 2;
    localparam int unsigned CA_IP_LSB  = 8;
    localparam int unsigned CA_TI      = 30;
    localparam int unsigned CA_BD      = 31;

    localparam logic [31:0] CONFIG_VAL = 32'h0000_8000;

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: prescaled Count, Compare and sticky timer interrupt.
module cp0_timer #(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);
    localparam int unsigned PW = 5;

    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic          ti_q, ti_d;
    logic          tick;

    // Prescaler keeps its phase across Count writes; a Compare write always clears TI.
    always_comb begin
        tick      = (presc_q == PW'(COUNT_DIV - 1));
        presc_d   = tick ? '0 : presc_q + PW'(1);
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        if (count_we_i) begin
            count_d = wdata_i;
        end else if (tick) begin
            count_d = count_q + 32'd1;
            if (count_d == compare_q) ti_d = 1'b1;
        end
        if (compare_we_i) begin
            compare_d = wdata_i;
            ti_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_ctrl.sv
// CP0 system-control unit: register file, exception/ERET commit, interrupt request and read mux.
module cp0_ctrl
    import cp0_pkg::*;
#(
    parameter int unsigned HW_INT_NUM = 6,
    parameter int unsigned COUNT_DIV  = 2,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [31:0] PRID_VAL   = 32'h004C_0102
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [31:0]           wdata_i,
    input  logic [4:0]            raddr_i,
    output logic [31:0]           rdata_o,
    input  logic [HW_INT_NUM-1:0] int_i,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exc_code_i,
    input  logic [31:0]           exc_pc_i,
    input  logic                  exc_ds_i,
    input  logic [31:0]           exc_bad_i,
    input  logic                  eret_i,
    output logic                  int_req_o,
    output logic                  flush_o,
    output logic [31:0]           redirect_o,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o
);
    logic [31:0] count, compare;
    logic        ti;

    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d, ie_q, ie_d;
    logic [1:0]  sw_ip_q, sw_ip_d;
    logic        bd_q, bd_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d, badv_q, badv_d;
    logic        int_req_q, int_req_d, flush_q, flush_d;
    logic [31:0] redirect_q, redirect_d;

    logic [5:0]  ip_hw;
    logic [7:0]  ip;
    logic [31:0] status_w, cause_w;
    logic        wr_status, wr_cause, wr_epc;

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk          (clk),
        .rst          (rst),
        .count_we_i   (we_i && (waddr_i == REG_COUNT)),
        .compare_we_i (we_i && (waddr_i == REG_COMPARE)),
        .wdata_i      (wdata_i),
        .count_o      (count),
        .compare_o    (compare),
        .ti_o         (ti)
    );

    // Hardware IP bits track the interrupt lines live; the timer shares IP7.
    always_comb begin
        ip_hw    = 6'(int_i);
        ip_hw[5] = ip_hw[5] | ti;
        ip       = {ip_hw, sw_ip_q};
        status_w = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
        cause_w  = {bd_q, ti, 14'b0, ip, 1'b0, exc_code_q, 2'b0};
    end

    // MTC0 applies first; a committed exception or ERET then overrides the fields it owns.
    always_comb begin
        wr_status  = we_i && (waddr_i == REG_STATUS);
        wr_cause   = we_i && (waddr_i == REG_CAUSE);
        wr_epc     = we_i && (waddr_i == REG_EPC);
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        sw_ip_d    = sw_ip_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        badv_d     = badv_q;
        flush_d    = 1'b0;
        redirect_d = redirect_q;
        int_req_d  = ie_q & ~exl_q & (|(ip & im_q));
        if (wr_status) begin
            im_d  = wdata_i[15:8];
            exl_d = wdata_i[ST_EXL];
            ie_d  = wdata_i[ST_IE];
        end
        if (wr_cause) sw_ip_d = wdata_i[9:8];
        if (wr_epc)   epc_d   = wdata_i;
        if (exc_valid_i) begin
            exc_code_d = exc_code_i;
            if (!exl_q) begin
                epc_d = exc_ds_i ? exc_pc_i - 32'd4 : exc_pc_i;
                bd_d  = exc_ds_i;
            end
            exl_d = 1'b1;
            if ((exc_code_i == EXC_ADEL) || (exc_code_i == EXC_ADES)) badv_d = exc_bad_i;
            flush_d    = 1'b1;
            redirect_d = EXC_VECTOR;
        end else if (eret_i) begin
            exl_d      = 1'b0;
            flush_d    = 1'b1;
            redirect_d = wr_epc ? wdata_i : epc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            sw_ip_q    <= '0;
            bd_q       <= 1'b0;
            exc_code_q <= '0;
            epc_q      <= '0;
            badv_q     <= '0;
            int_req_q  <= 1'b0;
            flush_q    <= 1'b0;
            redirect_q <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            sw_ip_q    <= sw_ip_d;
            bd_q       <= bd_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
            badv_q     <= badv_d;
            int_req_q  <= int_req_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
        end
    end

    always_comb begin
        case (raddr_i)
            REG_BADVADDR: rdata_o = badv_q;
            REG_COUNT:    rdata_o = count;
            REG_COMPARE:  rdata_o = compare;
            REG_STATUS:   rdata_o = status_w;
            REG_CAUSE:    rdata_o = cause_w;
            REG_EPC:      rdata_o = epc_q;
            REG_PRID:     rdata_o = PRID_VAL;
            REG_CONFIG:   rdata_o = CONFIG_VAL;
            default:      rdata_o = 32'h0;
        endcase
    end

    assign int_req_o  = int_req_q;
    assign flush_o    = flush_q;
    assign redirect_o = redirect_q;
    assign status_o   = status_w;
    assign cause_o    = cause_w;
    assign epc_o      = epc_q;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Self-checking bench for cp0_ctrl: cycle-level reference model plus directed scenarios.
module tb_cp0_ctrl;
    localparam int unsigned HW  = 2;
    localparam int unsigned DIV = 2;
    localparam logic [31:0] VEC  = 32'hBFC0_0380;
    localparam logic [31:0] PRID = 32'h004C_0102;

    logic          clk, rst, we_i, exc_valid_i, exc_ds_i, eret_i;
    logic [4:0]    waddr_i, raddr_i, exc_code_i;
    logic [31:0]   wdata_i, exc_pc_i, exc_bad_i, rdata_o;
    logic [HW-1:0] int_i;
    logic          int_req_o, flush_o;
    logic [31:0]   redirect_o, status_o, cause_o, epc_o;

    cp0_ctrl #(.HW_INT_NUM(HW), .COUNT_DIV(DIV), .EXC_VECTOR(VEC), .PRID_VAL(PRID)) dut (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .raddr_i(raddr_i), .rdata_o(rdata_o), .int_i(int_i), .exc_valid_i(exc_valid_i),
        .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i), .exc_ds_i(exc_ds_i), .exc_bad_i(exc_bad_i),
        .eret_i(eret_i), .int_req_o(int_req_o), .flush_o(flush_o), .redirect_o(redirect_o),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference state, held as architectural fields.
    int          m_cycles;
    logic [31:0] m_count, m_compare, m_epc, m_badv, m_redirect;
    logic [7:0]  m_im;
    logic [1:0]  m_sw;
    logic [4:0]  m_code;
    logic        m_ti, m_exl, m_ie, m_bd, m_flush, m_int_req;
    logic        m_tick, m_nreq, m_old_exl;

    function automatic logic [7:0] m_ip();
        logic [7:0] ip = 8'h0;
        for (int i = 0; i < HW; i++) ip[2+i] = int_i[i];
        ip[7]   = ip[7] | m_ti;
        ip[1:0] = m_sw;
        return ip;
    endfunction

    function automatic logic [31:0] m_status();
        return 32'h0040_0000 + (32'(m_im) << 8) + (32'(m_exl) << 1) + 32'(m_ie);
    endfunction

    function automatic logic [31:0] m_cause();
        return (32'(m_bd) << 31) + (32'(m_ti) << 30) + (32'(m_ip()) << 8) + (32'(m_code) << 2);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status();
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            5'd15:   return PRID;
            5'd16:   return 32'h0000_8000;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cycles = 0; m_count = 0; m_compare = 0; m_epc = 0; m_badv = 0; m_redirect = 0;
            m_im = 0; m_sw = 0; m_code = 0; m_ti = 0; m_exl = 0; m_ie = 0; m_bd = 0;
            m_flush = 0; m_int_req = 0;
        end else begin
            m_nreq = m_ie && !m_exl && ((m_ip() & m_im) != 8'h0);
            m_tick = (m_cycles % DIV) == (DIV - 1);
            m_cycles++;
            if (we_i && waddr_i == 5'd9) m_count = wdata_i;
            else if (m_tick) begin
                m_count = m_count + 1;
                if (m_count == m_compare) m_ti = 1'b1;
            end
            if (we_i && waddr_i == 5'd11) begin m_compare = wdata_i; m_ti = 1'b0; end
            m_old_exl = m_exl;
            if (we_i && waddr_i == 5'd12) begin
                m_im = wdata_i[15:8]; m_exl = wdata_i[1]; m_ie = wdata_i[0];
            end
            if (we_i && waddr_i == 5'd13) m_sw = wdata_i[9:8];
            if (we_i && waddr_i == 5'd14) m_epc = wdata_i;
            m_flush = 1'b0;
            if (exc_valid_i) begin
                m_code = exc_code_i;
                if (!m_old_exl) begin
                    m_epc = exc_pc_i - (exc_ds_i ? 32'd4 : 32'd0);
                    m_bd  = exc_ds_i;
                end
                m_exl = 1'b1;
                if (exc_code_i == 5'd4 || exc_code_i == 5'd5) m_badv = exc_bad_i;
                m_flush = 1'b1; m_redirect = VEC;
            end else if (eret_i) begin
                m_exl = 1'b0; m_flush = 1'b1; m_redirect = m_epc;
            end
            m_int_req = m_nreq;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rdata", rdata_o, m_read(raddr_i));
            chk("status", status_o, m_status());
            chk("cause", cause_o, m_cause());
            chk("epc", epc_o, m_epc);
            chk("int_req", 32'(int_req_o), 32'(m_int_req));
            chk("flush", 32'(flush_o), 32'(m_flush));
            if (m_flush) chk("redirect", redirect_o, m_redirect);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; wdata_i = d;
        step();
        we_i = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input string name, input logic [31:0] exp);
        raddr_i = a; #1;
        chk(name, rdata_o, exp);
    endtask

    task automatic set_exc(input logic [4:0] c, input logic [31:0] pc, input logic ds, input logic [31:0] bad);
        exc_valid_i = 1'b1; exc_code_i = c; exc_pc_i = pc; exc_ds_i = ds; exc_bad_i = bad;
    endtask

    task automatic clr_exc();
        exc_valid_i = 1'b0; exc_code_i = '0; exc_pc_i = '0; exc_ds_i = 1'b0; exc_bad_i = '0;
    endtask

    initial begin
        rst = 1'b1; we_i = 1'b0; waddr_i = '0; wdata_i = '0; raddr_i = 5'd9;
        int_i = '0; eret_i = 1'b0; clr_exc();
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_status", status_o, 32'h0040_0000);
        chk("rst_cause", cause_o, 32'h0);
        chk("rst_epc", epc_o, 32'h0);
        chk("rst_flush", 32'(flush_o), 32'h0);
        chk("rst_redirect", redirect_o, 32'h0);
        rd(5'd9, "rst_count", 32'h0);
        rst = 1'b0;

        // Timer match and TI clear.
        mtc0(5'd11, 32'd5);
        repeat (9) step();
        rd(5'd9, "t1_count", 32'd5);
        chk("t1_ti", 32'(cause_o[30]), 32'd1);
        chk("t1_ip7", 32'(cause_o[15]), 32'd1);
        mtc0(5'd11, 32'd1000);
        chk("t1_ti_clr", 32'(cause_o[30]), 32'd0);

        // Interrupt request and EXL masking.
        mtc0(5'd12, 32'h0000_0401);
        int_i = 2'b01;
        step();
        chk("t2_int_req", 32'(int_req_o), 32'd1);
        mtc0(5'd12, 32'h0000_0403);
        step();
        chk("t2_int_masked", 32'(int_req_o), 32'd0);

        // Delay-slot AdEL exception.
        mtc0(5'd12, 32'h0000_0401);
        set_exc(5'd4, 32'h8000_0104, 1'b1, 32'h0000_1235);
        step(); clr_exc();
        chk("t3_flush", 32'(flush_o), 32'd1);
        chk("t3_redirect", redirect_o, 32'hBFC0_0380);
        chk("t3_epc", epc_o, 32'h8000_0100);
        chk("t3_bd", 32'(cause_o[31]), 32'd1);
        chk("t3_code", 32'(cause_o[6:2]), 32'd4);
        rd(5'd8, "t3_badv", 32'h0000_1235);
        step();
        chk("t3_flush_end", 32'(flush_o), 32'd0);

        // Nested exception then ERET.
        set_exc(5'd8, 32'h8000_0200, 1'b0, 32'h0000_FFFF);
        step(); clr_exc();
        chk("t4_epc_kept", epc_o, 32'h8000_0100);
        chk("t4_code", 32'(cause_o[6:2]), 32'd8);
        rd(5'd8, "t4_badv_kept", 32'h0000_1235);
        eret_i = 1'b1; step(); eret_i = 1'b0;
        chk("t4_eret_redirect", redirect_o, 32'h8000_0100);
        chk("t4_eret_exl", 32'(status_o[1]), 32'd0);

        // Same-cycle priority cases.
        set_exc(5'd12, 32'h8000_0300, 1'b0, 32'h0);
        mtc0(5'd14, 32'hDEAD_0000); clr_exc();
        chk("t5_epc_exc_wins", epc_o, 32'h8000_0300);
        chk("t5_im_kept", 32'(status_o[15:8]), 32'h04);
        eret_i = 1'b1;
        mtc0(5'd14, 32'h1234_5678); eret_i = 1'b0;
        chk("t5_eret_fwd", redirect_o, 32'h1234_5678);
        set_exc(5'd13, 32'h8000_0400, 1'b0, 32'h0);
        mtc0(5'd12, 32'h0000_FF01); clr_exc();
        chk("t5_status_merge", status_o, 32'h0040_FF03);
        set_exc(5'd9, 32'h8000_0500, 1'b0, 32'h0);
        mtc0(5'd14, 32'hCAFE_0000); clr_exc();
        chk("t5_nested_epc_wr", epc_o, 32'hCAFE_0000);
        eret_i = 1'b1; step(); eret_i = 1'b0;

        // Read-only registers, write masks and unmapped reads.
        mtc0(5'd15, 32'h0); rd(5'd15, "prid", PRID);
        mtc0(5'd8, 32'h0);  rd(5'd8, "badv_ro", 32'h0000_1235);
        rd(5'd16, "config", 32'h0000_8000);
        rd(5'd3, "unmapped", 32'h0);
        mtc0(5'd12, 32'hFFFF_FFFF);
        chk("status_mask", status_o, 32'h0040_FF03);
        mtc0(5'd12, 32'h0);
        mtc0(5'd13, 32'hFFFF_FFFF);
        chk("cause_sw_ip", 32'(cause_o[9:8]), 32'h3);
        mtc0(5'd13, 32'h0);

        // Count wrap.
        mtc0(5'd9, 32'hFFFF_FFFF);
        repeat (2) step();
        rd(5'd9, "count_wrap", 32'h0);

        // Reset mid-count with TI set and a flush pending.
        int_i = '0;
        mtc0(5'd9, 32'd0);
        mtc0(5'd11, 32'd3);
        repeat (8) step();
        chk("t6_ti_pre", 32'(cause_o[30]), 32'd1);
        set_exc(5'd10, 32'h8000_0600, 1'b0, 32'h0);
        step(); clr_exc();
        rst = 1'b1; step();
        chk("t6_status", status_o, 32'h0040_0000);
        chk("t6_cause", cause_o, 32'h0);
        chk("t6_epc", epc_o, 32'h0);
        chk("t6_flush", 32'(flush_o), 32'd0);
        chk("t6_redirect", redirect_o, 32'h0);
        rd(5'd9, "t6_count", 32'h0);
        rst = 1'b0;
        int_i = 2'b11;
        step();
        chk("t6_ip_narrow", 32'(cause_o[15:8]), 32'h0C);
        mtc0(5'd11, 32'd2);
        repeat (6) step();
        chk("t6_ip_ti", 32'(cause_o[15:8]), 32'h8C);

        step();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
